temp_zone_scheduler: RTL and testbench
======================================

// Module: temp_zone_scheduler
// PURPOSE
//  Time-shares one hysteresis comparator between NZONES room zones.
//  Zones raise service requests; a round-robin arbiter picks one; a 4-state FSM loads its
//  operands, evaluates them and updates that zone's heat/cool outputs.
//  Sits above the comparator datapath and replaces one controller per room in multi-zone builds.
// PARAMETERS
//  NZONES  4  number of zones served (2..8)
//  TW      7  temperature/threshold width in bits, unsigned
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-low reset
//  start      in   1          global enable; low = no new evaluations are granted
//  zone_req   in   NZONES     per-zone service request pulse/level
//  troom_bus  in   NZONES*TW  zone z room temp at [z*TW +: TW]
//  tref_bus   in   NZONES*TW  zone z setpoint, same packing
//  dt_bus     in   NZONES*TW  zone z hysteresis band, same packing
//  h          out  NZONES     per-zone heater command, registered
//  c          out  NZONES     per-zone cooler command, registered
//  busy       out  1          high while FSM is not IDLE
//  zone_idx   out  $clog2(NZONES) zone currently granted/in flight
//  done       out  1          one-cycle pulse when a zone's h/c has been written
// BEHAVIOUR
//  Reset (reset=0, async): h=0, c=0, busy=0, done=0, zone_idx=0, pending=0, rr_ptr=0,
//   state=IDLE. Mid-evaluation reset aborts the evaluation and leaves no partial update.
//  pending[z]: set on any cycle zone_req[z]=1; cleared at the UPD edge for the served zone.
//   Set and clear in the same cycle -> set wins (zone re-serviced later).
//  FSM IDLE->LOAD->CMP->UPD->IDLE:
//   IDLE: if start=1 and pending!=0, grant the first pending zone at or after rr_ptr
//     (wrapping NZONES-1 -> 0); register zone_idx; go to LOAD. Otherwise stay in IDLE.
//   LOAD: latch troom/tref/dt of zone_idx into operand registers; go to CMP.
//   CMP: register comparator flags lo_trip, lo_clr, hi_trip, hi_clr; go to UPD.
//   UPD: write h[z] and c[z]; pulse done; clear pending[z]; rr_ptr = z+1 (mod NZONES);
//     go to IDLE.
//  Latency: grant edge E0; h/c/done visible after E3, i.e. 3 cycles after grant.
//   Back-to-back service rate is 1 zone per 4 cycles.
//  start falling mid-flight: current evaluation completes; no new grant issued. Pending bits
//   are retained.
//  Hysteresis for zone z, using current h[z]/c[z]:
//   lo_trip = troom < tref-dt, lo_clr = troom >= tref, hi_trip = troom > tref+dt,
//   hi_clr = troom <= tref.
//   h: 0->1 on lo_trip; 1->0 on lo_clr; otherwise hold.
//   c: 0->1 on hi_trip; 1->0 on hi_clr; otherwise hold.
//   h and c are never both 1. If a set and a hold would conflict, the new direction wins and
//   the other output clears.
//  Arithmetic: widen to TW+1 bits. tref-dt saturates at 0; tref+dt saturates at 2^TW-1.
//   Example: tref=5, dt=10 -> low threshold 0, so lo_trip is never true.
//  dt=0: plain comparator behaviour; troom==tref gives h=0 and c=0.
//  Zones not being served hold h/c unchanged indefinitely.
// STRUCTURE
//  Shared package temp_pkg: state enum {IDLE,LOAD,CMP,UPD}, TW default, comparator flag
//   struct.
//  Sub-module temp_zone_cmp: purely combinational; saturating thresholds and the four flags.
//   Its output is registered in CMP state.
//  Top level: pending register, round-robin arbiter (rotate/priority-encode), FSM, operand
//   registers, per-zone h/c registers.
// TESTING
//  1. Reset mid-CMP with h[1]=1 -> all h/c=0, busy=0 immediately, no done pulse; pending=0
//     after release.
//  2. start=1, zone_req=4'b0001 for 1 cycle, z0: troom=10, tref=20, dt=3 -> done and h[0]=1
//     exactly 3 cycles after grant; c[0]=0.
//  3. z0 heating, troom raised to 19 then 20 with re-requests -> h[0] holds at 19, clears at
//     20. Then troom=24: c stays 0; troom=24 with dt=3: c[0]=1 (24>23).
//  4. zone_req=4'b1111 in one cycle -> grants in order 0,1,2,3, done every 4 cycles. With
//     rr_ptr=2 and req=4'b0101, zone 2 is served before zone 0.
//  5. Saturation: tref=5, dt=10, troom=0 -> h=0. tref=120, dt=20, troom=127 -> c=0.
//     troom=127 with tref=100, dt=20 -> c=1.
//  6. start dropped in LOAD with zones 1,3 pending -> zone 1 completes; zone 3 waits;
//     start=1 resumes with zone 3. A zone_req[1] coinciding with zone 1's UPD edge ->
//     zone 1 served again.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the multi-zone temperature scheduler.
//   state_t      : scheduler FSM states (IDLE -> LOAD -> CMP -> UPD -> IDLE)
//   cmp_flags_t  : the four hysteresis comparator flags for one zone
//   TW_DEFAULT   : default temperature/threshold width in bits
package temp_pkg;

    localparam int TW_DEFAULT     = 7;
    localparam int NZONES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        UPD  = 2'd3
    } state_t;

    typedef struct packed {
        logic lo_trip;   // troom <  tref - dt  (heater turn-on)
        logic lo_clr;    // troom >= tref       (heater turn-off)
        logic hi_trip;   // troom >  tref + dt  (cooler turn-on)
        logic hi_clr;    // troom <= tref       (cooler turn-off)
    } cmp_flags_t;

endpackage

// File: rtl/temp_zone_cmp.sv
// Combinational hysteresis comparator shared by all zones.
// Ports:
//   troom  in  TW   room temperature of the zone being evaluated
//   tref   in  TW   setpoint
//   dt     in  TW   hysteresis half-band
//   flags  out      lo_trip / lo_clr / hi_trip / hi_clr
// Thresholds are computed one bit wider than TW and saturate at 0 and 2^TW-1,
// so a band wider than the setpoint (or than the headroom) never wraps.
module temp_zone_cmp
    import temp_pkg::*;
#(
    parameter int TW = TW_DEFAULT
) (
    input  logic [TW-1:0] troom,
    input  logic [TW-1:0] tref,
    input  logic [TW-1:0] dt,
    output cmp_flags_t    flags
);

    localparam logic [TW:0] MAX_VAL = {1'b0, {TW{1'b1}}};

    logic [TW:0] troom_w;
    logic [TW:0] tref_w;
    logic [TW:0] dt_w;
    logic [TW:0] sum_w;
    logic [TW:0] lo_thr;
    logic [TW:0] hi_thr;

    always_comb begin
        troom_w = {1'b0, troom};
        tref_w  = {1'b0, tref};
        dt_w    = {1'b0, dt};
        sum_w   = tref_w + dt_w;

        lo_thr  = (tref_w >= dt_w) ? (tref_w - dt_w) : '0;
        hi_thr  = (sum_w > MAX_VAL) ? MAX_VAL : sum_w;

        flags.lo_trip = (troom_w <  lo_thr);
        flags.lo_clr  = (troom_w >= tref_w);
        flags.hi_trip = (troom_w >  hi_thr);
        flags.hi_clr  = (troom_w <= tref_w);
    end

endmodule

// File: rtl/temp_zone_scheduler.sv
// Time-shares one hysteresis comparator between NZONES room zones.
// Requests are latched into a pending vector, a round-robin arbiter grants one
// zone, and a 4-state FSM loads its operands, registers the comparator flags and
// finally updates that zone's heater/cooler outputs.
// Ports:
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous active-low reset
//   start      in   1          global enable for new grants
//   zone_req   in   NZONES     per-zone service request
//   troom_bus  in   NZONES*TW  zone z room temp at [z*TW +: TW]
//   tref_bus   in   NZONES*TW  zone z setpoint, same packing
//   dt_bus     in   NZONES*TW  zone z hysteresis band, same packing
//   h          out  NZONES     per-zone heater command (registered)
//   c          out  NZONES     per-zone cooler command (registered)
//   busy       out  1          FSM not in IDLE
//   zone_idx   out  IW         zone granted / in flight
//   done       out  1          one-cycle pulse after a zone's h/c was written
module temp_zone_scheduler
    import temp_pkg::*;
#(
    parameter int NZONES = NZONES_DEFAULT,
    parameter int TW     = TW_DEFAULT,
    localparam int IW    = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NZONES-1:0]    zone_req,
    input  logic [NZONES*TW-1:0] troom_bus,
    input  logic [NZONES*TW-1:0] tref_bus,
    input  logic [NZONES*TW-1:0] dt_bus,
    output logic [NZONES-1:0]    h,
    output logic [NZONES-1:0]    c,
    output logic                 busy,
    output logic [IW-1:0]        zone_idx,
    output logic                 done
);

    state_t              state_reg, state_next;
    logic [NZONES-1:0]   pending_reg, pending_next;
    logic [IW-1:0]       rr_ptr_reg;
    logic [IW-1:0]       zone_idx_reg;
    logic [NZONES-1:0]   h_reg, c_reg;
    logic                done_reg;

    logic [TW-1:0]       troom_reg, tref_reg, dt_reg;
    cmp_flags_t          flags_reg;
    cmp_flags_t          flags_cmb;

    logic [TW-1:0]       troom_arr [NZONES];
    logic [TW-1:0]       tref_arr  [NZONES];
    logic [TW-1:0]       dt_arr    [NZONES];
    logic [NZONES-1:0]   clear_mask;

    logic                grant_valid;
    logic [IW-1:0]       grant_idx;
    logic                grant_fire;

    logic                h_cur, c_cur, h_upd, c_upd;

    // Unpack the flat operand buses and build the served-zone clear mask.
    generate
        for (genvar gi = 0; gi < NZONES; gi++) begin : g_zone
            assign troom_arr[gi]  = troom_bus[gi*TW +: TW];
            assign tref_arr[gi]   = tref_bus[gi*TW +: TW];
            assign dt_arr[gi]     = dt_bus[gi*TW +: TW];
            assign clear_mask[gi] = (state_reg == UPD) && (zone_idx_reg == IW'(gi));
        end
    endgenerate

    // Round-robin arbiter: first pending zone at or after rr_ptr, wrapping.
    // Scanning offsets from the far end down lets the nearest one win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NZONES - 1; i >= 0; i--) begin
            if (pending_reg[(int'(rr_ptr_reg) + i) % NZONES]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(rr_ptr_reg) + i) % NZONES);
            end
        end
    end

    assign grant_fire = (state_reg == IDLE) && start && grant_valid;

    // A request arriving on the same edge as the clear re-arms the zone.
    assign pending_next = (pending_reg & ~clear_mask) | zone_req;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_fire) state_next = LOAD;
            LOAD:    state_next = CMP;
            CMP:     state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    temp_zone_cmp #(.TW(TW)) u_cmp (
        .troom (troom_reg),
        .tref  (tref_reg),
        .dt    (dt_reg),
        .flags (flags_cmb)
    );

    // Hysteresis update for the served zone. A freshly set direction forces
    // the opposite output off so h and c are never both high.
    always_comb begin
        h_cur = h_reg[zone_idx_reg];
        c_cur = c_reg[zone_idx_reg];
        h_upd = (!h_cur && flags_reg.lo_trip) ||
                (h_cur && !flags_reg.lo_clr && !(!c_cur && flags_reg.hi_trip));
        c_upd = (!c_cur && flags_reg.hi_trip) ||
                (c_cur && !flags_reg.hi_clr && !(!h_cur && flags_reg.lo_trip));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            rr_ptr_reg   <= '0;
            zone_idx_reg <= '0;
            troom_reg    <= '0;
            tref_reg     <= '0;
            dt_reg       <= '0;
            flags_reg    <= '0;
            done_reg     <= 1'b0;
            h_reg        <= '0;
            c_reg        <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            done_reg    <= (state_reg == UPD);

            if (grant_fire) begin
                zone_idx_reg <= grant_idx;
            end

            if (state_reg == LOAD) begin
                troom_reg <= troom_arr[zone_idx_reg];
                tref_reg  <= tref_arr[zone_idx_reg];
                dt_reg    <= dt_arr[zone_idx_reg];
            end

            if (state_reg == CMP) begin
                flags_reg <= flags_cmb;
            end

            if (state_reg == UPD) begin
                rr_ptr_reg <= (int'(zone_idx_reg) == NZONES - 1) ? '0 : zone_idx_reg + 1'b1;
                for (int z = 0; z < NZONES; z++) begin
                    if (zone_idx_reg == IW'(z)) begin
                        h_reg[z] <= h_upd;
                        c_reg[z] <= c_upd;
                    end
                end
            end
        end
    end

    assign h        = h_reg;
    assign c        = c_reg;
    assign busy     = (state_reg != IDLE);
    assign zone_idx = zone_idx_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_temp_zone_scheduler.sv
module tb_temp_zone_scheduler;

    localparam int NZ = 4;
    localparam int TW = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NZ-1:0]     zone_req;
    logic [NZ*TW-1:0]  troom_bus, tref_bus, dt_bus;
    logic [NZ-1:0]     h, c;
    logic              busy;
    logic [1:0]        zone_idx;
    logic              done;

    int checks = 0;
    int errors = 0;

    temp_zone_scheduler #(.NZONES(NZ), .TW(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .zone_req  (zone_req),
        .troom_bus (troom_bus),
        .tref_bus  (tref_bus),
        .dt_bus    (dt_bus),
        .h         (h),
        .c         (c),
        .busy      (busy),
        .zone_idx  (zone_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_zone(input int z, input int tr, input int tf, input int d);
        troom_bus[z*TW +: TW] = TW'(tr);
        tref_bus[z*TW +: TW]  = TW'(tf);
        dt_bus[z*TW +: TW]    = TW'(d);
    endtask

    // Request held high across exactly one rising edge; returns on the
    // following falling edge.
    task automatic pulse_req(input logic [NZ-1:0] m);
        @(negedge clk);
        zone_req = m;
        @(negedge clk);
        zone_req = '0;
    endtask

    task automatic wait_done(input int maxc, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic serve(input int z, output int cyc, output bit seen);
        pulse_req(NZ'(1 << z));
        wait_done(12, cyc, seen);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; zone_req = '0;
        troom_bus = '0; tref_bus = '0; dt_bus = '0;
        repeat (3) @(negedge clk);
        checks++; if (h !== 4'b0000) begin errors++; $display("FAIL rst_h: got %b expected 0000", h); end
        checks++; if (c !== 4'b0000) begin errors++; $display("FAIL rst_c: got %b expected 0000", c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (zone_idx !== 2'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", zone_idx); end
        reset = 1'b1;
        $display("reset: h=%b c=%b busy=%b", h, c, busy);
    endtask

    task automatic test_latency();
        set_zone(0, 10, 20, 3);
        start = 1'b1;
        pulse_req(4'b0001);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b expected 1", busy); end
        checks++; if (zone_idx !== 2'd0) begin errors++; $display("FAIL lat_idx: got %0d expected 0", zone_idx); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_early_done: got %b expected 0", done); end
        checks++; if (h[0] !== 1'b0) begin errors++; $display("FAIL lat_early_h0: got %b expected 0", h[0]); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL lat_done: got %b expected 1", done); end
        checks++; if (h[0] !== 1'b1) begin errors++; $display("FAIL lat_h0: got %b expected 1", h[0]); end
        checks++; if (c[0] !== 1'b0) begin errors++; $display("FAIL lat_c0: got %b expected 0", c[0]); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lat_done_pulse: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_idle: got %b expected 0", busy); end
        $display("latency: zone 0 h=%b c=%b", h[0], c[0]);
    endtask

    task automatic test_hysteresis();
        int  cyc;
        bit  seen;
        set_zone(0, 19, 20, 3);
        serve(0, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hys19_done: got %b expected 1", seen); end
        checks++; if (h[0] !== 1'b1) begin errors++; $display("FAIL hys19_h0: got %b expected 1", h[0]); end
        $display("hyst: troom=19 h0=%b c0=%b", h[0], c[0]);
        set_zone(0, 20, 20, 3);
        serve(0, cyc, seen);
        checks++; if (h[0] !== 1'b0) begin errors++; $display("FAIL hys20_h0: got %b expected 0", h[0]); end
        $display("hyst: troom=20 h0=%b c0=%b", h[0], c[0]);
        set_zone(0, 24, 20, 5);
        serve(0, cyc, seen);
        checks++; if (c[0] !== 1'b0) begin errors++; $display("FAIL hys24w_c0: got %b expected 0", c[0]); end
        $display("hyst: troom=24 dt=5 h0=%b c0=%b", h[0], c[0]);
        set_zone(0, 24, 20, 3);
        serve(0, cyc, seen);
        checks++; if (c[0] !== 1'b1) begin errors++; $display("FAIL hys24_c0: got %b expected 1", c[0]); end
        checks++; if (h[0] !== 1'b0) begin errors++; $display("FAIL hys24_h0: got %b expected 0", h[0]); end
        $display("hyst: troom=24 dt=3 h0=%b c0=%b", h[0], c[0]);
    endtask

    task automatic test_reset_mid_cmp();
        int  cyc;
        bit  seen;
        set_zone(1, 10, 20, 3);
        serve(1, cyc, seen);
        checks++; if (h[1] !== 1'b1) begin errors++; $display("FAIL rmc_h1: got %b expected 1", h[1]); end
        set_zone(1, 30, 20, 3);
        pulse_req(4'b0010);
        @(negedge clk);                 // LOAD
        zone_req = 4'b0100;             // zone 2 becomes pending
        @(negedge clk);                 // CMP
        zone_req = '0;
        reset = 1'b0;
        #1;
        checks++; if (h !== 4'b0000) begin errors++; $display("FAIL rmc_h: got %b expected 0000", h); end
        checks++; if (c !== 4'b0000) begin errors++; $display("FAIL rmc_c: got %b expected 0000", c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmc_done: got %b expected 0", done); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_post_busy%0d: got %b expected 0", i, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmc_post_done%0d: got %b expected 0", i, done); end
        end
        $display("reset mid-CMP: h=%b c=%b busy=%b", h, c, busy);
    endtask

    task automatic test_round_robin();
        int  cyc;
        bit  seen;
        for (int z = 0; z < NZ; z++) set_zone(z, 50, 50, 0);
        pulse_req(4'b1111);
        for (int k = 0; k < NZ; k++) begin
            @(negedge clk);
            checks++; if (zone_idx !== 2'(k)) begin errors++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, zone_idx, k); end
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done%0d: got %b expected 1", k, done); end
            $display("round robin: served zone %0d", zone_idx);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", busy); end
        serve(1, cyc, seen);            // rr_ptr now 2
        pulse_req(4'b0101);
        @(negedge clk);
        checks++; if (zone_idx !== 2'd2) begin errors++; $display("FAIL rr_ptr2_first: got %0d expected 2", zone_idx); end
        wait_done(8, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rr_ptr2_done: got %b expected 1", seen); end
        @(negedge clk);
        checks++; if (zone_idx !== 2'd0) begin errors++; $display("FAIL rr_ptr2_second: got %0d expected 0", zone_idx); end
        wait_done(8, cyc, seen);
        $display("round robin: rr_ptr=2 req=0101 served 2 then %0d", zone_idx);
    endtask

    task automatic test_saturation();
        int  cyc;
        bit  seen;
        set_zone(2, 0, 5, 10);
        serve(2, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sat_lo_done: got %b expected 1", seen); end
        checks++; if (h[2] !== 1'b0) begin errors++; $display("FAIL sat_lo_h2: got %b expected 0", h[2]); end
        set_zone(2, 127, 120, 20);
        serve(2, cyc, seen);
        checks++; if (c[2] !== 1'b0) begin errors++; $display("FAIL sat_hi_c2: got %b expected 0", c[2]); end
        set_zone(2, 127, 100, 20);
        serve(2, cyc, seen);
        checks++; if (c[2] !== 1'b1) begin errors++; $display("FAIL sat_127_c2: got %b expected 1", c[2]); end
        set_zone(2, 100, 100, 0);
        serve(2, cyc, seen);
        checks++; if ({h[2], c[2]} !== 2'b00) begin errors++; $display("FAIL dt0_eq_hc: got %b%b expected 00", h[2], c[2]); end
        set_zone(2, 99, 100, 0);
        serve(2, cyc, seen);
        checks++; if ({h[2], c[2]} !== 2'b10) begin errors++; $display("FAIL dt0_lo_hc: got %b%b expected 10", h[2], c[2]); end
        $display("saturation: h2=%b c2=%b", h[2], c[2]);
    endtask

    task automatic test_start_pause();
        int  cyc;
        bit  seen;
        serve(0, cyc, seen);            // rr_ptr now 1
        pulse_req(4'b1010);
        @(negedge clk);                 // LOAD of zone 1
        checks++; if (zone_idx !== 2'd1) begin errors++; $display("FAIL sp_grant1: got %0d expected 1", zone_idx); end
        start = 1'b0;
        wait_done(8, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sp_done1: got %b expected 1", seen); end
        checks++; if (zone_idx !== 2'd1) begin errors++; $display("FAIL sp_idx1: got %0d expected 1", zone_idx); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sp_hold%0d: got %b expected 0", i, busy); end
        end
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_resume_busy: got %b expected 1", busy); end
        checks++; if (zone_idx !== 2'd3) begin errors++; $display("FAIL sp_resume_idx: got %0d expected 3", zone_idx); end
        wait_done(8, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL sp_done3: got %b expected 1", seen); end
        $display("start pause: resumed with zone 3");
        // Zone 1 re-requests on the very edge its UPD clears pending.
        pulse_req(4'b0010);
        @(negedge clk);
        checks++; if (zone_idx !== 2'd1) begin errors++; $display("FAIL co_grant: got %0d expected 1", zone_idx); end
        @(negedge clk);
        @(negedge clk);                 // UPD
        zone_req = 4'b0010;
        @(negedge clk);
        zone_req = '0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL co_done: got %b expected 1", done); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL co_reserve_busy: got %b expected 1", busy); end
        checks++; if (zone_idx !== 2'd1) begin errors++; $display("FAIL co_reserve_idx: got %0d expected 1", zone_idx); end
        wait_done(8, cyc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL co_reserve_done: got %b expected 1", seen); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL co_settle: got %b expected 0", busy); end
        $display("start pause: zone 1 re-served after coinciding request");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hysteresis();
        test_reset_mid_cmp();
        test_round_robin();
        test_saturation();
        test_start_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
